gb_csr_ram_bank: RTL and testbench
==================================

// Module: gb_csr_ram_bank
// PURPOSE
//  Parametrised host-bus slave: NREG read/write CSRs, one write-1-to-clear sticky status
//  word with interrupt, and one dual-use RAM (host R/W, fabric read port), all decoded
//  from the ghostbus local bus. Generalises fixed per-module CSR/RAM decode into one
//  reusable block instantiated per subsystem, with a registered read path.
// PARAMETERS
//  AW       12      host address width
//  DW       32      host data width; CSR and status width
//  LAW      9       local window width; window = 2**LAW words
//  BASE     0       window base; must be aligned to 2**LAW
//  NREG     4       number of CSRs, 1..(RAM_BASE-1)
//  REG_INIT 0       reset value of every CSR
//  RAM_AW   6       RAM address width (depth 2**RAM_AW)
//  RAM_DW   8       RAM data width, <= DW
//  RAM_BASE 'h100   RAM offset in window; aligned to 2**RAM_AW; NREG < RAM_BASE
// PORTS
//  gb_clk      in   1           sole clock; host bus and fabric port
//  gb_rst      in   1           async active-high reset
//  gb_addr     in   AW          host word address
//  gb_dout     in   DW          host write data
//  gb_we       in   1           host write strobe; gb_we=0 means read cycle
//  gb_din      out  DW          host read data, registered
//  reg_out     out  NREG*DW     CSR values; CSR k at [k*DW +: DW]
//  reg_wstb    out  NREG        1-cycle pulse, bit k, when host writes CSR k
//  status_set  in   DW          fabric sticky-set pulses, per bit
//  irq         out  1           registered OR of status bits
//  ram_raddr   in   RAM_AW      fabric RAM read address
//  ram_rdata   out  RAM_DW      fabric RAM read data
// BEHAVIOUR
//  - hit = gb_addr[AW-1:LAW]==BASE[AW-1:LAW]; off = gb_addr[LAW-1:0].
//  - Map: off 0..NREG-1 = CSR[off]; off NREG = STATUS; RAM_BASE..RAM_BASE+2**RAM_AW-1 = RAM;
//    all other offsets unmapped: writes ignored, reads return 0.
//  - Write (hit & gb_we), taking effect at that gb_clk edge:
//    CSR k <= gb_dout, reg_wstb[k]=1 for exactly the next cycle.
//    STATUS <= (STATUS & ~gb_dout) | status_set; set wins over a same-cycle clear.
//    RAM[off-RAM_BASE] <= gb_dout[RAM_DW-1:0].
//  - Read (gb_we=0): gb_din <= mapped value, zero-extended; gb_din <= 0 when !hit.
//    Latency 1 cycle: data valid the cycle after the address. RAM read is synchronous.
//  - During a write cycle gb_din holds its previous value.
//  - Host read of RAM during a same-cycle fabric read: both served, no conflict.
//  - Host write and fabric read of the same RAM word in one cycle: fabric gets old data.
//  - STATUS: every cycle with no STATUS write, STATUS <= STATUS | status_set.
//    irq <= |STATUS, i.e. 1 cycle behind STATUS.
//  - ram_rdata <= RAM[ram_raddr] each cycle (1-cycle latency); not reset.
//  - Reset (async assert, sync deassert external): every CSR = REG_INIT,
//    STATUS = 0, gb_din = 0, reg_wstb = 0, irq = 0.
//    RAM contents are preserved and not initialised; a bus access in flight at reset is
//    dropped.
//  - Widths: DW-bit CSR/STATUS; RAM writes truncate to RAM_DW; no arithmetic wrap.
// CONFIGURATION
//  GB_CSR_RDPIPE_EN defined: adds an output stage after the read mux; host read latency
//    2 cycles. gb_din holds through write cycles as before; stage reset to 0.
//    reg_wstb, irq and fabric RAM timing are unchanged.
//  Undefined: read latency 1 cycle as above.
// TESTING
//  1 Reset with REG_INIT='h5A -> reg_out all 'h5A, gb_din=0, irq=0, reg_wstb=0.
//  2 Write 'hDEADBEEF to BASE+2 -> reg_out[95:64]='hDEADBEEF, reg_wstb=4'b0100 for 1 cycle;
//    read BASE+2 -> gb_din='hDEADBEEF after 1 cycle (2 with GB_CSR_RDPIPE_EN).
//  3 Pulse status_set='h11 -> STATUS='h11, irq=1 next cycle; write 'h01 to BASE+NREG
//    with same-cycle status_set='h01 -> STATUS stays 'h11; then write 'h11 -> STATUS=0,
//    irq=0.
//  4 Write 'h1A5 to RAM offset 'h13F -> host read 'h000000A5; fabric ram_raddr='h3F ->
//    ram_rdata='hA5; same-cycle write/fabric read of one word returns old data.
//  5 Read unmapped offset 'h1FF and out-of-window address BASE+'h200 -> gb_din=0; writes
//    there leave all CSRs, STATUS and RAM unchanged.
//  6 Assert gb_rst mid-write burst -> CSRs=REG_INIT, STATUS=0 immediately; RAM retains
//    data written before reset.

Source files
------------

// File: rtl/gb_csr_ram_bank.sv
// Ghostbus slave: NREG CSRs, a W1C sticky status word with irq, and a host/fabric RAM.
// Define GB_CSR_RDPIPE_EN to add an output stage on the host read path (2-cycle read latency).
module gb_csr_ram_bank #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int LAW = 9,
  parameter int BASE = 0,
  parameter int NREG = 4,
  parameter logic [DW-1:0] REG_INIT = '0,
  parameter int RAM_AW = 6,
  parameter int RAM_DW = 8,
  parameter int RAM_BASE = 'h100
) (
  input  logic                gb_clk,
  input  logic                gb_rst,
  input  logic [AW-1:0]       gb_addr,
  input  logic [DW-1:0]       gb_dout,
  input  logic                gb_we,
  output logic [DW-1:0]       gb_din,
  output logic [NREG*DW-1:0]  reg_out,
  output logic [NREG-1:0]     reg_wstb,
  input  logic [DW-1:0]       status_set,
  output logic                irq,
  input  logic [RAM_AW-1:0]   ram_raddr,
  output logic [RAM_DW-1:0]   ram_rdata
);

  localparam logic [AW-LAW-1:0] BASE_HI = (AW-LAW)'(BASE >> LAW);
  localparam int RAM_END = RAM_BASE + (1 << RAM_AW);

  logic              hit;
  logic [LAW-1:0]    off;
  logic [31:0]       off32;
  logic              is_status;
  logic              is_ram;
  logic              wr;
  logic              rd;
  logic [NREG-1:0]   csr_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [DW-1:0]     status;
  logic [DW-1:0]     rd_mux;
  logic [DW-1:0]     rd_q;
  logic              rd_ram_q;
  logic [RAM_DW-1:0] host_ram_q;
  logic [DW-1:0]     rd_data;
  logic [RAM_DW-1:0] mem [2**RAM_AW];

  assign hit       = (gb_addr[AW-1:LAW] == BASE_HI);
  assign off       = gb_addr[LAW-1:0];
  assign off32     = 32'(off);
  assign is_status = (off32 == 32'(NREG));
  assign is_ram    = (off32 >= 32'(RAM_BASE)) && (off32 < 32'(RAM_END));
  assign ram_idx   = off[RAM_AW-1:0];
  assign wr        = hit && gb_we;
  assign rd        = !gb_we;

  // Register/status part of the read mux; RAM words come from the synchronous port below.
  always_comb begin
    csr_sel = '0;
    rd_mux  = '0;
    for (int k = 0; k < NREG; k++) begin
      csr_sel[k] = (off32 == 32'(k));
    end
    if (hit) begin
      for (int k = 0; k < NREG; k++) begin
        if (csr_sel[k]) rd_mux = reg_out[k*DW +: DW];
      end
      if (is_status) rd_mux = status;
    end
  end

  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      reg_out  <= {NREG{REG_INIT}};
      reg_wstb <= '0;
      status   <= '0;
      irq      <= 1'b0;
      rd_q     <= '0;
      rd_ram_q <= 1'b0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (wr && csr_sel[k]) reg_out[k*DW +: DW] <= gb_dout;
      end
      reg_wstb <= wr ? csr_sel : '0;
      // Set bits are OR-ed after the clear so a same-cycle set always survives.
      if (wr && is_status) status <= (status & ~gb_dout) | status_set;
      else                 status <= status | status_set;
      irq <= |status;
      if (rd) begin
        rd_q     <= rd_mux;
        rd_ram_q <= hit && is_ram;
      end
    end
  end

  // RAM storage is never reset; both read ports see pre-write data on a same-cycle write.
  always_ff @(posedge gb_clk) begin
    if (wr && is_ram) mem[ram_idx] <= gb_dout[RAM_DW-1:0];
    if (rd) host_ram_q <= mem[ram_idx];
    ram_rdata <= mem[ram_raddr];
  end

  assign rd_data = rd_ram_q ? DW'(host_ram_q) : rd_q;

`ifdef GB_CSR_RDPIPE_EN
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) gb_din <= '0;
    else        gb_din <= rd_data;
  end
`else
  assign gb_din = rd_data;
`endif

endmodule

// File: tb/tb_gb_csr_ram_bank.sv
// Directed bench for gb_csr_ram_bank: vector table for the address map plus hand sequences.
module tb_gb_csr_ram_bank;

`ifdef GB_CSR_RDPIPE_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic         clk;
  logic         rst;
  logic [11:0]  gb_addr;
  logic [31:0]  gb_dout;
  logic         gb_we;
  logic [31:0]  gb_din;
  logic [127:0] reg_out;
  logic [3:0]   reg_wstb;
  logic [31:0]  status_set;
  logic         irq;
  logic [5:0]   ram_raddr;
  logic [7:0]   ram_rdata;

  int n_cmp;
  int n_bad;

  gb_csr_ram_bank #(.REG_INIT(32'h5A)) dut (
    .gb_clk(clk), .gb_rst(rst), .gb_addr(gb_addr), .gb_dout(gb_dout), .gb_we(gb_we),
    .gb_din(gb_din), .reg_out(reg_out), .reg_wstb(reg_wstb), .status_set(status_set),
    .irq(irq), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_wstb;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic host_write(input logic [11:0] a, input logic [31:0] d, input logic [31:0] s);
    gb_we = 1'b1; gb_addr = a; gb_dout = d; status_set = s;
    tick();
    gb_we = 1'b0; status_set = '0;
  endtask

  task automatic host_read(input logic [11:0] a, output logic [31:0] d);
    gb_we = 1'b0; gb_addr = a;
    repeat (RD_LAT) tick();
    d = gb_din;
  endtask

  logic [31:0] rd;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; gb_we = 1'b0; gb_addr = '0; gb_dout = '0; status_set = '0; ram_raddr = '0;

    vecs[0] = '{12'h000, 32'h11111111, 4'b0001, 32'h11111111};
    vecs[1] = '{12'h001, 32'h22220000, 4'b0010, 32'h22220000};
    vecs[2] = '{12'h003, 32'hCAFEF00D, 4'b1000, 32'hCAFEF00D};
    vecs[3] = '{12'h100, 32'h000001FF, 4'b0000, 32'h000000FF};
    vecs[4] = '{12'h13F, 32'h000001A5, 4'b0000, 32'h000000A5};
    vecs[5] = '{12'h1FF, 32'hFFFFFFFF, 4'b0000, 32'h00000000};
    vecs[6] = '{12'h200, 32'h12345678, 4'b0000, 32'h00000000};
    vecs[7] = '{12'h005, 32'h0BADF00D, 4'b0000, 32'h00000000};
    vecs[8] = '{12'h0FF, 32'h87654321, 4'b0000, 32'h00000000};

    // 1: reset values
    repeat (2) @(negedge clk);
    check("rst_reg_out", reg_out, {4{32'h5A}});
    check("rst_gb_din", gb_din, 0);
    check("rst_irq", irq, 0);
    check("rst_wstb", reg_wstb, 0);
    rst = 1'b0;
    tick();
    host_read(12'h004, rd);
    check("rst_status", rd, 0);

    // 2: CSR write strobe and read-back, gb_din held through a write
    host_write(12'h002, 32'hDEADBEEF, 0);
    check("csr2_value", reg_out[95:64], 32'hDEADBEEF);
    check("csr2_wstb", reg_wstb, 4'b0100);
    host_read(12'h002, rd);
    check("csr2_wstb_clear", reg_wstb, 0);
    check("csr2_read", rd, 32'hDEADBEEF);
    host_write(12'h0FF, 32'h0, 0);
    check("din_hold_on_write", gb_din, 32'hDEADBEEF);

    // map table, including unmapped and out-of-window writes
    for (int i = 0; i < 9; i++) begin
      host_write(vecs[i].addr, vecs[i].wdata, 0);
      check($sformatf("vec%0d_wstb", i), reg_wstb, vecs[i].exp_wstb);
      host_read(vecs[i].addr, rd);
      check($sformatf("vec%0d_read", i), rd, vecs[i].exp_rd);
    end
    check("csrs_after_table", reg_out, {32'hCAFEF00D, 32'hDEADBEEF, 32'h22220000, 32'h11111111});
    host_read(12'h004, rd);
    check("status_after_table", rd, 0);

    // 3: sticky status, set beats clear, W1C, irq lag
    status_set = 32'h11;
    tick();
    status_set = '0;
    check("irq_lag", irq, 0);
    tick();
    check("irq_set", irq, 1);
    host_write(12'h004, 32'h01, 32'h01);
    host_read(12'h004, rd);
    check("status_set_wins", rd, 32'h11);
    host_write(12'h004, 32'h11, 0);
    host_read(12'h004, rd);
    check("status_cleared", rd, 0);
    check("irq_cleared", irq, 0);

    // 4: fabric port, same-cycle write gives old data
    ram_raddr = 6'h3F;
    tick();
    check("fabric_read", ram_rdata, 8'hA5);
    host_write(12'h13F, 32'h0000005C, 0);
    check("fabric_old_data", ram_rdata, 8'hA5);
    host_read(12'h13F, rd);
    check("fabric_new_data", ram_rdata, 8'h5C);
    check("host_ram_read", rd, 32'h5C);
    ram_raddr = 6'h00;
    tick();
    check("fabric_ram0", ram_rdata, 8'hFF);

    // 6: reset in the middle of a write burst
    status_set = 32'h80;
    tick();
    status_set = '0;
    tick();
    check("irq_before_rst", irq, 1);
    gb_we = 1'b1; gb_addr = 12'h000; gb_dout = 32'hAAAA5555;
    tick();
    gb_addr = 12'h001; gb_dout = 32'h00000012;
    #2 rst = 1'b1;
    #1;
    check("midrst_reg_out", reg_out, {4{32'h5A}});
    check("midrst_irq", irq, 0);
    check("midrst_wstb", reg_wstb, 0);
    check("midrst_gb_din", gb_din, 0);
    @(negedge clk);
    gb_we = 1'b0;
    tick();
    rst = 1'b0;
    host_read(12'h001, rd);
    check("post_rst_csr1", rd, 32'h5A);
    host_read(12'h004, rd);
    check("post_rst_status", rd, 0);
    host_read(12'h13F, rd);
    check("post_rst_ram", rd, 32'h5C);
    host_read(12'h100, rd);
    check("post_rst_ram0", rd, 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
